// File: rtl/pi_inc_mux.sv
// Time-multiplexed incremental PI controller for the motor and dribbler speed
// loops. One shared datapath walks the channels in order. For each channel it
// forms a deadbanded error and computes delta = KA*err - KB*prev_err. The
// output is either that delta, or (ACCUM=1) a clamped running sum of deltas.
//
//   state  | meaning
//   IDLE   | waiting for start; gains and inputs are latched on the accept edge
//   ERR    | deadbanded error of channel c
//   PMUL   | P = KA*err on the shared multiplier
//   IMUL   | I = KB*prev_err[c] on the shared multiplier
//   ACC    | result[c] and prev_err[c] update; go to the next channel or DONE
//   DONE   | done pulse cycle, busy already low
module pi_inc_mux #(
  parameter int                  CH       = 4,
  parameter int                  W        = 32,
  parameter int                  SCALE_SH = 7,
  parameter logic signed [W-1:0] DEADBAND = 32,
  parameter logic [7:0]          IR_MASK  = 8'h01,
  parameter logic signed [W-1:0] IR_SET   = -40,
  parameter bit                  ACCUM    = 1'b0,
  parameter logic signed [W-1:0] OUT_MAX  = {1'b0, {(W-1){1'b1}}},
  parameter logic signed [W-1:0] OUT_MIN  = {1'b1, {(W-1){1'b0}}},
  parameter logic signed [W-1:0] KA_RST   = 360,
  parameter logic signed [W-1:0] KB_RST   = 210
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [CH*W-1:0] set,
  input  logic [CH*W-1:0] feedback,
  input  logic            infrain,
  input  logic            gain_we,
  input  logic [W-1:0]    ka_in,
  input  logic [W-1:0]    kb_in,
  input  logic            clr,
  output logic            busy,
  output logic            done,
  output logic [CH*W-1:0] result,
  output logic [CH-1:0]   sat
);

  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_PMUL, S_IMUL, S_ACC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   c_q, c_d;
  logic            busy_q, busy_d, done_q, done_d, ir_q, ir_d;
  logic [W-1:0]    ka_q, ka_d, kb_q, kb_d, ka_sh_q, ka_sh_d, kb_sh_q, kb_sh_d;
  logic [W-1:0]    err_q, err_d, p_q, p_d, i_q, i_d;
  logic [W-1:0]    set_q [CH];
  logic [W-1:0]    set_d [CH];
  logic [W-1:0]    fb_q  [CH];
  logic [W-1:0]    fb_d  [CH];
  logic [W-1:0]    prev_q[CH];
  logic [W-1:0]    prev_d[CH];
  logic [W-1:0]    res_q [CH];
  logic [W-1:0]    res_d [CH];
  logic [CH-1:0]   sat_q, sat_d;

  logic [W-1:0]    set_eff, err_raw, err_db, mul_a, mul_b, mul_lo, delta, acc_val;
  logic [W:0]      acc_s;
  logic            acc_clip;

  // Channel datapath: error with IR override and deadband, shared multiplier, clamp.
  always_comb begin
    set_eff = set_q[c_q];
    if (ir_q && IR_MASK[c_q] && (set_q[c_q] != '0)) set_eff = IR_SET;
    err_raw = (set_eff << SCALE_SH) - fb_q[c_q];
    err_db  = (($signed(err_raw) > -DEADBAND) && ($signed(err_raw) < DEADBAND)) ? '0 : err_raw;
    mul_a   = (state_q == S_PMUL) ? ka_q  : kb_q;
    mul_b   = (state_q == S_PMUL) ? err_q : prev_q[c_q];
    mul_lo  = mul_a * mul_b;
    delta   = p_q - i_q;
    acc_s   = {res_q[c_q][W-1], res_q[c_q]} + {delta[W-1], delta};
    acc_val  = acc_s[W-1:0];
    acc_clip = 1'b0;
    if ($signed(acc_s) > $signed({OUT_MAX[W-1], OUT_MAX})) begin
      acc_val  = OUT_MAX;
      acc_clip = 1'b1;
    end else if ($signed(acc_s) < $signed({OUT_MIN[W-1], OUT_MIN})) begin
      acc_val  = OUT_MIN;
      acc_clip = 1'b1;
    end
  end

  // Sequencer next state; clr wins over everything except shadow gain loads.
  always_comb begin
    state_d = state_q;  c_d = c_q;  busy_d = busy_q;  done_d = 1'b0;  ir_d = ir_q;
    ka_d = ka_q;  kb_d = kb_q;  ka_sh_d = ka_sh_q;  kb_sh_d = kb_sh_q;
    err_d = err_q;  p_d = p_q;  i_d = i_q;
    set_d = set_q;  fb_d = fb_q;  prev_d = prev_q;  res_d = res_q;  sat_d = sat_q;
    if (gain_we) begin
      ka_sh_d = ka_in;
      kb_sh_d = kb_in;
    end
    if (clr) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      sat_d   = '0;
      for (int i = 0; i < CH; i++) begin
        prev_d[i] = '0;
        res_d[i]  = '0;
      end
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          for (int i = 0; i < CH; i++) begin
            set_d[i] = set[i*W +: W];
            fb_d[i]  = feedback[i*W +: W];
          end
          ir_d    = infrain;
          ka_d    = ka_sh_q;
          kb_d    = kb_sh_q;
          c_d     = '0;
          busy_d  = 1'b1;
          state_d = S_ERR;
        end
        S_ERR: begin
          err_d   = err_db;
          state_d = S_PMUL;
        end
        S_PMUL: begin
          p_d     = mul_lo;
          state_d = S_IMUL;
        end
        S_IMUL: begin
          i_d     = mul_lo;
          state_d = S_ACC;
        end
        S_ACC: begin
          if (ACCUM) begin
            res_d[c_q] = acc_val;
            sat_d[c_q] = acc_clip;
          end else begin
            res_d[c_q] = delta;
            sat_d[c_q] = 1'b0;
          end
          prev_d[c_q] = err_q;
          if (c_q == CW'(CH-1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            c_d     = c_q + CW'(1);
            state_d = S_ERR;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // All state registers, async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  c_q <= '0;  busy_q <= 1'b0;  done_q <= 1'b0;  ir_q <= 1'b0;
      ka_q <= KA_RST;  kb_q <= KB_RST;  ka_sh_q <= KA_RST;  kb_sh_q <= KB_RST;
      err_q <= '0;  p_q <= '0;  i_q <= '0;  sat_q <= '0;
      for (int i = 0; i < CH; i++) begin
        set_q[i] <= '0;  fb_q[i] <= '0;  prev_q[i] <= '0;  res_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;  c_q <= c_d;  busy_q <= busy_d;  done_q <= done_d;  ir_q <= ir_d;
      ka_q <= ka_d;  kb_q <= kb_d;  ka_sh_q <= ka_sh_d;  kb_sh_q <= kb_sh_d;
      err_q <= err_d;  p_q <= p_d;  i_q <= i_d;  sat_q <= sat_d;
      set_q <= set_d;  fb_q <= fb_d;  prev_q <= prev_d;  res_q <= res_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sat  = sat_q;

  for (genvar g = 0; g < CH; g++) begin : g_out
    assign result[g*W +: W] = res_q[g];
  end

endmodule

// File: tb/tb_pi_inc_mux.sv
// Bench for pi_inc_mux: a delta-mode and an accumulate-mode instance share the
// stimulus; a reference model queues expected outputs at each accepted start
// and a monitor compares them whenever done pulses.
module tb_pi_inc_mux;
  localparam int CH = 4;
  localparam int W  = 32;
  localparam int MAX1 = 100000;

  typedef struct packed {
    logic [CH*W-1:0] r;
    logic [CH-1:0]   s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, start, infrain, gain_we, clr;
  logic [CH*W-1:0] set_i, fb_i;
  logic [W-1:0] ka_in, kb_in;
  logic busy0, done0, busy1, done1;
  logic [CH*W-1:0] res0, res1;
  logic [CH-1:0] sat0, sat1;

  int errors = 0;
  int checks = 0;
  exp_t q0[$];
  exp_t q1[$];

  int m_prev[2][CH];
  int m_res[2][CH];
  logic [CH-1:0] m_sat[2];
  int m_ka, m_kb;

  always #5 clk = ~clk;

  pi_inc_mux #(.CH(CH), .W(W)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .set(set_i), .feedback(fb_i),
    .infrain(infrain), .gain_we(gain_we), .ka_in(ka_in), .kb_in(kb_in), .clr(clr),
    .busy(busy0), .done(done0), .result(res0), .sat(sat0));

  pi_inc_mux #(.CH(CH), .W(W), .ACCUM(1'b1), .OUT_MAX(32'sd100000)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .set(set_i), .feedback(fb_i),
    .infrain(infrain), .gain_we(gain_we), .ka_in(ka_in), .kb_in(kb_in), .clr(clr),
    .busy(busy1), .done(done1), .result(res1), .sat(sat1));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input logic [CH*W-1:0] act, input logic [CH*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int r0(input int c);
    return int'($signed(res0[c*W +: W]));
  endfunction
  function automatic int r1(input int c);
    return int'($signed(res1[c*W +: W]));
  endfunction

  function automatic logic [CH*W-1:0] pk(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  task automatic model_clear(input bit gains);
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) begin
        m_prev[d][c] = 0;
        m_res[d][c]  = 0;
      end
      m_sat[d] = '0;
    end
    if (gains) begin
      m_ka = 360;
      m_kb = 210;
    end
  endtask

  // One full update of every channel using the gains in force at acceptance.
  task automatic model_start(input logic [CH*W-1:0] s, input logic [CH*W-1:0] f, input bit ir);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) begin
        int se, fb, err, p, i, delta;
        longint sum;
        se = int'($signed(s[c*W +: W]));
        fb = int'($signed(f[c*W +: W]));
        if (ir && c == 0 && se != 0) se = -40;
        err = int'(longint'(se) * 128 - longint'(fb));
        if (err > -32 && err < 32) err = 0;
        p = int'(longint'(m_ka) * longint'(err));
        i = int'(longint'(m_kb) * longint'(m_prev[d][c]));
        delta = int'(longint'(p) - longint'(i));
        if (d == 0) begin
          m_res[d][c] = delta;
          m_sat[d][c] = 1'b0;
        end else begin
          sum = longint'(m_res[d][c]) + longint'(delta);
          m_sat[d][c] = 1'b0;
          if (sum > MAX1) begin
            sum = MAX1;
            m_sat[d][c] = 1'b1;
          end else if (sum < -64'sd2147483648) begin
            sum = -64'sd2147483648;
            m_sat[d][c] = 1'b1;
          end
          m_res[d][c] = int'(sum);
        end
        m_prev[d][c] = err;
        e.r[c*W +: W] = m_res[d][c];
      end
      e.s = m_sat[d];
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  // Scoreboard monitor: compare on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) chk("sb0_unexpected_done", 1, 0);
      else begin
        e = q0.pop_front();
        chkv("sb0_result", res0, e.r);
        chk("sb0_sat", longint'(sat0), longint'(e.s));
      end
    end
    if (done1) begin
      if (q1.size() == 0) chk("sb1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        chkv("sb1_result", res1, e.r);
        chk("sb1_sat", longint'(sat1), longint'(e.s));
      end
    end
  end

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    model_clear(1'b0);
    @(negedge clk);
    clr = 1'b0;
    chkv("clr_res0", res0, '0);
    chkv("clr_res1", res1, '0);
    chk("clr_sat1", longint'(sat1), 0);
  endtask

  // act: 0 plain, 1 start while busy, 2 gain_we mid-run, 3 reset mid-run, 4 clr mid-run
  task automatic run(input logic [CH*W-1:0] s, input logic [CH*W-1:0] f, input bit ir,
                     input int act, input bit gw, input int gka, input int gkb);
    int n, ndone;
    @(negedge clk);
    set_i = s; fb_i = f; infrain = ir; start = 1'b1;
    if (gw) begin
      gain_we = 1'b1; ka_in = gka; kb_in = gkb;
    end
    model_start(s, f, ir);
    if (gw) begin
      m_ka = gka; m_kb = gkb;
    end
    @(posedge clk);
    #1 start = 1'b0; gain_we = 1'b0;
    ndone = 0;
    n = 0;
    while (n < 4*CH + 12) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done0) begin
        ndone++;
        if (ndone == 1) chk("done_latency", n, 4*CH);
      end
      if (act == 4 && n == 6) begin
        chk("clr_abort_busy", longint'(busy0), 0);
        chkv("clr_abort_res", res0, '0);
      end
      start = 1'b0; gain_we = 1'b0; clr = 1'b0; rst_n = 1'b1;
      if (act == 1 && n == 3) start = 1'b1;
      if (act == 2 && n == 3) begin
        gain_we = 1'b1; ka_in = 500; kb_in = 300;
        m_ka = 500; m_kb = 300;
      end
      if (act == 3 && n == 5) begin
        rst_n = 1'b0;
        q0.delete(); q1.delete();
        model_clear(1'b1);
        #1;
        chk("rst_busy0", longint'(busy0), 0);
        chk("rst_busy1", longint'(busy1), 0);
        chk("rst_done0", longint'(done0), 0);
        chkv("rst_res0", res0, '0);
        chkv("rst_res1", res1, '0);
        chk("rst_sat1", longint'(sat1), 0);
      end
      if (act == 4 && n == 5) begin
        clr = 1'b1;
        q0.delete(); q1.delete();
        model_clear(1'b0);
      end
    end
    chk("done_count", ndone, (act == 3 || act == 4) ? 0 : 1);
  endtask

  initial begin
    int acc_exp[4];
    int acc_sat[4];
    acc_exp = '{46080, 65280, 84480, 100000};
    acc_sat = '{0, 0, 0, 1};
    rst_n = 1'b0; start = 1'b0; infrain = 1'b0; gain_we = 1'b0; clr = 1'b0;
    set_i = '0; fb_i = '0; ka_in = '0; kb_in = '0;
    model_clear(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chkv("reset_res0", res0, '0);
    chk("reset_busy0", longint'(busy0), 0);
    chk("reset_done0", longint'(done0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(pk(0,0,0,0), pk(0,0,0,0), 0, 0, 0, 0, 0);
    chkv("zero_run", res0, '0);
    run(pk(1,0,0,0), pk(0,0,0,0), 0, 0, 0, 0, 0);
    chk("p_only", r0(0), 46080);
    run(pk(1,0,0,0), pk(0,0,0,0), 0, 0, 0, 0, 0);
    chk("pi_step", r0(0), 19200);
    run(pk(1,1,0,0), pk(0,100,0,0), 0, 0, 0, 0, 0);
    chk("deadband_in", r0(1), 0);
    run(pk(1,1,0,0), pk(0,96,0,0), 0, 0, 0, 0, 0);
    chk("deadband_edge", r0(1), 11520);

    do_clr();
    run(pk(5,5,0,0), pk(0,0,0,0), 1, 0, 0, 0, 0);
    chk("ir_override", r0(0), -1843200);
    chk("ir_unmasked", r0(1), 230400);
    do_clr();
    run(pk(0,0,0,0), pk(0,0,0,0), 1, 0, 0, 0, 0);
    chk("ir_zero_set", r0(0), 0);

    do_clr();
    for (int k = 0; k < 4; k++) begin
      run(pk(1,0,0,0), pk(0,0,0,0), 0, 0, 0, 0, 0);
      chk("accum_res", r1(0), acc_exp[k]);
      chk("accum_sat", longint'(sat1[0]), acc_sat[k]);
    end
    do_clr();

    run(pk(1,2,0,0), pk(0,0,0,0), 0, 1, 0, 0, 0);
    run(pk(1,2,0,0), pk(0,0,0,0), 0, 2, 0, 0, 0);
    run(pk(1,2,0,0), pk(0,0,0,0), 0, 0, 0, 0, 0);
    run(pk(1,2,3,0), pk(0,0,0,0), 0, 0, 1, 111, 77);
    run(pk(1,2,3,0), pk(0,0,0,0), 0, 0, 0, 0, 0);
    run(pk(3,2,1,0), pk(5,0,0,0), 0, 3, 0, 0, 0);
    run(pk(1,0,0,0), pk(0,0,0,0), 0, 0, 0, 0, 0);
    chk("post_reset_gains", r0(0), 46080);
    run(pk(3,2,1,4), pk(5,0,0,0), 0, 4, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      logic [CH*W-1:0] s, f;
      for (int c = 0; c < CH; c++) begin
        int sv, fv;
        sv = $urandom_range(0, 4) == 0 ? 0 : int'($urandom_range(0, 600)) - 300;
        case ($urandom_range(0, 3))
          0: fv = sv * 128 + int'($urandom_range(0, 80)) - 40;
          1: fv = int'($urandom);
          default: fv = int'($urandom_range(0, 80000)) - 40000;
        endcase
        s[c*W +: W] = sv;
        f[c*W +: W] = fv;
      end
      run(s, f, $urandom_range(0, 1) == 1, $urandom_range(0, 2),
          $urandom_range(0, 4) == 0, $urandom_range(0, 1000), $urandom_range(0, 1000));
      if ($urandom_range(0, 9) == 0) do_clr();
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
